// File: rtl/cpu_ctrl_pkg.sv
// Purpose : shared constants and types for the CPU pipeline control blocks.
// Latency : n/a (declarations only).
// Contents: stall bit indices, stall masks, divider sequencer state enum.
package cpu_ctrl_pkg;

   // One stall bit per pipeline register, PC first; 1 = hold that stage.
   localparam int STALL_PC  = 0;
   localparam int STALL_IF  = 1;
   localparam int STALL_ID  = 2;
   localparam int STALL_EX  = 3;
   localparam int STALL_MEM = 4;
   localparam int STALL_WB  = 5;
   localparam int STALL_W   = STALL_WB + 1;

   typedef logic [STALL_W-1:0] stall_t;

   // Each mask holds every stage up to and including the stalling one, so a
   // bubble is injected into the first stage that keeps moving.
   localparam stall_t STALL_NONE = '0;
   localparam stall_t STALL_LOAD = (stall_t'(1) << STALL_PC) |
                                   (stall_t'(1) << STALL_IF) |
                                   (stall_t'(1) << STALL_ID);
   localparam stall_t STALL_EX_M = STALL_LOAD | (stall_t'(1) << STALL_EX);
   localparam stall_t STALL_MEM_M = STALL_EX_M | (stall_t'(1) << STALL_MEM);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DIV_WAIT = 2'd1,
      DIV_DONE = 2'd2
   } div_state_t;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Purpose : bundle of hazard inputs, divider handshake and stall outputs.
// Latency : n/a (wires only).
// Modports: master = pipeline/divider side, slave = stall controller.
interface pipe_stall_ctrl_if;
   import cpu_ctrl_pkg::*;

   logic       id_re1;
   logic       id_re2;
   logic [4:0] id_raddr1;
   logic [4:0] id_raddr2;
   logic       ex_is_load;
   logic       ex_rf_we;
   logic [4:0] ex_rf_waddr;
   logic       ex_div_req;
   logic       div_ready;
   logic       div_cancel;
   logic       mem_stallreq;
   stall_t     stall;
   logic       div_start;
   logic       div_annul;
   logic       div_busy;
   logic       div_timeout;
   logic       load_use;

   modport master (
      output id_re1, id_re2, id_raddr1, id_raddr2,
             ex_is_load, ex_rf_we, ex_rf_waddr,
             ex_div_req, div_ready, div_cancel, mem_stallreq,
      input  stall, div_start, div_annul, div_busy, div_timeout, load_use
   );

   modport slave (
      input  id_re1, id_re2, id_raddr1, id_raddr2,
             ex_is_load, ex_rf_we, ex_rf_waddr,
             ex_div_req, div_ready, div_cancel, mem_stallreq,
      output stall, div_start, div_annul, div_busy, div_timeout, load_use
   );

endinterface

// File: rtl/load_use_detect.sv
// Purpose : flags an ID operand read that depends on a load still in EX.
// Latency : combinational, same cycle.
// Ports   : re1/re2 + raddr1/raddr2 from ID, is_load/rf_we/waddr from EX, load_use out.
module load_use_detect (
   input  logic       re1,
   input  logic       re2,
   input  logic [4:0] raddr1,
   input  logic [4:0] raddr2,
   input  logic       is_load,
   input  logic       rf_we,
   input  logic [4:0] waddr,
   output logic       load_use
);

   logic hit1;
   logic hit2;

   assign hit1 = re1 && (raddr1 == waddr);
   assign hit2 = re2 && (raddr2 == waddr);

   // r0 is hard-wired zero, so a load targeting it never creates a dependency.
   assign load_use = is_load && rf_we && (waddr != 5'd0) && (hit1 || hit2);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Purpose : central stall controller; load-use, divider sequencing, memory stalls.
// Latency : all outputs combinational from state + inputs; state/cnt registered.
// Ports   : clk, rst (async, active-high), bus (pipe_stall_ctrl_if.slave).
module pipe_stall_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int DIV_TIMEOUT = 48,
   parameter int CNT_W       = 6
) (
   input  logic              clk,
   input  logic              rst,
   pipe_stall_ctrl_if.slave  bus
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_TIMEOUT - 1);

   div_state_t       state;
   div_state_t       state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             lu;
   logic             start_ok;
   logic             cnt_expired;

   load_use_detect u_load_use_detect (
      .re1      (bus.id_re1),
      .re2      (bus.id_re2),
      .raddr1   (bus.id_raddr1),
      .raddr2   (bus.id_raddr2),
      .is_load  (bus.ex_is_load),
      .rf_we    (bus.ex_rf_we),
      .waddr    (bus.ex_rf_waddr),
      .load_use (lu)
   );

   // A divide is only launched when the instruction can actually sit in EX:
   // not while memory freezes the pipe and not while it is being flushed.
   assign start_ok    = bus.ex_div_req && !bus.mem_stallreq && !bus.div_cancel;
   assign cnt_expired = (cnt == CNT_LAST);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (start_ok) begin
               state_nxt = DIV_WAIT;
               cnt_nxt   = '0;
            end
         end
         DIV_WAIT: begin
            // Cancel beats a coincident ready; the counter keeps running
            // through memory stalls so a lost divider still times out.
            if (bus.div_cancel) begin
               state_nxt = IDLE;
            end else if (bus.div_ready) begin
               state_nxt = DIV_DONE;
            end else if (cnt_expired) begin
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         DIV_DONE: begin
            // Stay until the divide result actually leaves EX.
            if (!bus.mem_stallreq || bus.div_cancel) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Output logic. rst gates the Mealy terms so nothing pulses while the
   // rest of the core is held in reset.
   always_comb begin
      bus.load_use    = lu;
      bus.div_start   = !rst && (state == IDLE) && start_ok;
      bus.div_timeout = !rst && (state == DIV_WAIT) && !bus.div_cancel &&
                        !bus.div_ready && cnt_expired;
      bus.div_annul   = !rst && (state == DIV_WAIT) &&
                        (bus.div_cancel || (!bus.div_ready && cnt_expired));
      bus.div_busy    = !rst && (state != IDLE);

      // DIV_DONE deliberately drops the EX hold so the result can advance.
      if (rst) begin
         bus.stall = STALL_NONE;
      end else if (bus.mem_stallreq) begin
         bus.stall = STALL_MEM_M;
      end else if ((state == DIV_WAIT) || ((state == IDLE) && start_ok)) begin
         bus.stall = STALL_EX_M;
      end else if (lu) begin
         bus.stall = STALL_LOAD;
      end else begin
         bus.stall = STALL_NONE;
      end
   end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
module tb_pipe_stall_ctrl;
   import cpu_ctrl_pkg::*;

   localparam int TO = 48;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pipe_stall_ctrl_if bus ();

   pipe_stall_ctrl #(.DIV_TIMEOUT(TO), .CNT_W(6)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: divider is either waiting (with an age), finishing, or free.
   bit   m_wait;
   bit   m_done;
   int   m_age;
   logic [5:0] e_stall;
   bit   e_start, e_annul, e_to, e_busy, e_lu;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h want %0h", tag, $time, obs, exp);
      end
   endtask

   // Mask that holds the first n stages.
   function automatic logic [5:0] hold(input int n);
      return 6'((1 << n) - 1);
   endfunction

   task automatic clear_inputs();
      bus.id_re1 = 0; bus.id_re2 = 0; bus.id_raddr1 = 0; bus.id_raddr2 = 0;
      bus.ex_is_load = 0; bus.ex_rf_we = 0; bus.ex_rf_waddr = 0;
      bus.ex_div_req = 0; bus.div_ready = 0; bus.div_cancel = 0; bus.mem_stallreq = 0;
   endtask

   task automatic model_reset();
      m_wait = 0; m_done = 0; m_age = 0;
   endtask

   // Wait for the quiet half of the cycle, predict, compare.
   task automatic settle();
      @(negedge clk);
      e_lu = bus.ex_is_load && bus.ex_rf_we && (bus.ex_rf_waddr != 0) &&
             ((bus.id_re1 && bus.id_raddr1 == bus.ex_rf_waddr) ||
              (bus.id_re2 && bus.id_raddr2 == bus.ex_rf_waddr));
      if (rst) begin
         e_start = 0; e_to = 0; e_annul = 0; e_busy = 0; e_stall = 0;
      end else begin
         e_start = !m_wait && !m_done && bus.ex_div_req && !bus.mem_stallreq && !bus.div_cancel;
         e_to    = m_wait && !bus.div_cancel && !bus.div_ready && (m_age == TO - 1);
         e_annul = m_wait && (bus.div_cancel || e_to);
         e_busy  = m_wait || m_done;
         if (bus.mem_stallreq)      e_stall = hold(5);
         else if (m_wait || e_start) e_stall = hold(4);
         else if (e_lu)             e_stall = hold(3);
         else                       e_stall = 0;
      end
      chk("stall",       32'(bus.stall),       32'(e_stall));
      chk("div_start",   32'(bus.div_start),   32'(e_start));
      chk("div_annul",   32'(bus.div_annul),   32'(e_annul));
      chk("div_timeout", 32'(bus.div_timeout), 32'(e_to));
      chk("div_busy",    32'(bus.div_busy),    32'(e_busy));
      chk("load_use",    32'(bus.load_use),    32'(e_lu));
   endtask

   // Advance the model across the rising edge, then step off it.
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else if (m_wait) begin
         if (bus.div_cancel) m_wait = 0;
         else if (bus.div_ready) begin m_wait = 0; m_done = 1; end
         else if (m_age == TO - 1) m_wait = 0;
         else m_age++;
      end else if (m_done) begin
         if (!bus.mem_stallreq || bus.div_cancel) m_done = 0;
      end else if (e_start) begin
         m_wait = 1; m_age = 0;
      end
      #1;
   endtask

   initial begin
      model_reset();
      clear_inputs();
      rst = 1;

      // Reset: outputs quiet even with requests present.
      bus.ex_div_req = 1; bus.mem_stallreq = 1;
      settle();
      chk("rst_stall", 32'(bus.stall), 32'(6'b000000));
      chk("rst_busy",  32'(bus.div_busy), 32'd0);
      tick();
      settle();
      tick();
      rst = 0;
      clear_inputs();

      // Load-use: one cycle of LOAD, then the load has moved on.
      bus.ex_is_load = 1; bus.ex_rf_we = 1; bus.ex_rf_waddr = 5;
      bus.id_re1 = 1; bus.id_raddr1 = 5;
      settle();
      chk("lu_stall", 32'(bus.stall), 32'(6'b000111));
      chk("lu_flag",  32'(bus.load_use), 32'd1);
      tick();
      bus.ex_is_load = 0;
      settle();
      chk("lu_after", 32'(bus.stall), 32'(6'b000000));
      tick();
      bus.ex_is_load = 1; bus.ex_rf_waddr = 0; bus.id_raddr1 = 0;
      settle();
      chk("lu_r0_stall", 32'(bus.stall), 32'(6'b000000));
      chk("lu_r0_flag",  32'(bus.load_use), 32'd0);
      tick();
      clear_inputs();

      // Divide with div_ready 33 cycles after start.
      for (int k = 0; k <= 35; k++) begin
         bus.ex_div_req = (k <= 34);
         bus.div_ready  = (k == 33);
         settle();
         if (k == 0)  chk("div_t_start", 32'(bus.div_start), 32'd1);
         if (k == 1)  chk("div_t1_busy", 32'(bus.div_busy), 32'd1);
         if (k == 20) chk("div_t20_stall", 32'(bus.stall), 32'(6'b001111));
         if (k == 33) chk("div_t33_stall", 32'(bus.stall), 32'(6'b001111));
         if (k == 34) begin
            chk("div_t34_stall", 32'(bus.stall), 32'(6'b000000));
            chk("div_t34_busy",  32'(bus.div_busy), 32'd1);
         end
         if (k == 35) chk("div_t35_busy", 32'(bus.div_busy), 32'd0);
         tick();
      end
      clear_inputs();

      // Timeout: no div_ready ever.
      for (int k = 0; k <= 49; k++) begin
         bus.ex_div_req = (k == 0);
         settle();
         if (k == 47) chk("to_early", 32'(bus.div_timeout), 32'd0);
         if (k == 48) begin
            chk("to_pulse", 32'(bus.div_timeout), 32'd1);
            chk("to_annul", 32'(bus.div_annul), 32'd1);
         end
         if (k == 49) chk("to_idle", 32'(bus.div_busy), 32'd0);
         tick();
      end
      clear_inputs();

      // Cancel coincident with ready: cancel wins, no DIV_DONE.
      for (int k = 0; k <= 7; k++) begin
         bus.ex_div_req = (k == 0);
         bus.div_cancel = (k == 5);
         bus.div_ready  = (k == 5);
         settle();
         if (k == 5) chk("cancel_annul", 32'(bus.div_annul), 32'd1);
         if (k == 6) chk("cancel_idle", 32'(bus.div_busy), 32'd0);
         tick();
      end
      clear_inputs();

      // Memory stall while in DIV_DONE.
      for (int k = 0; k <= 8; k++) begin
         bus.ex_div_req   = (k == 0);
         bus.div_ready    = (k == 3);
         bus.mem_stallreq = (k >= 4 && k <= 6);
         settle();
         if (k == 5) begin
            chk("mem_done_stall", 32'(bus.stall), 32'(6'b011111));
            chk("mem_done_busy",  32'(bus.div_busy), 32'd1);
         end
         if (k == 7) begin
            chk("mem_rel_stall", 32'(bus.stall), 32'(6'b000000));
            chk("mem_rel_busy",  32'(bus.div_busy), 32'd1);
         end
         if (k == 8) chk("mem_idle", 32'(bus.div_busy), 32'd0);
         tick();
      end
      clear_inputs();

      // Asynchronous reset in the middle of DIV_WAIT.
      for (int k = 0; k < 10; k++) begin
         bus.ex_div_req = (k == 0);
         settle();
         tick();
      end
      bus.ex_div_req = 1; bus.mem_stallreq = 1;
      rst = 1;
      #1;
      chk("arst_stall",   32'(bus.stall),       32'd0);
      chk("arst_busy",    32'(bus.div_busy),    32'd0);
      chk("arst_start",   32'(bus.div_start),   32'd0);
      chk("arst_annul",   32'(bus.div_annul),   32'd0);
      chk("arst_timeout", 32'(bus.div_timeout), 32'd0);
      model_reset();
      #1;
      rst = 0;
      clear_inputs();
      settle();
      chk("arst_idle", 32'(bus.div_busy), 32'd0);
      tick();

      // Randomized traffic against the model.
      for (int k = 0; k < 3000; k++) begin
         bus.id_re1       = 1'($urandom_range(0, 1));
         bus.id_re2       = 1'($urandom_range(0, 1));
         bus.id_raddr1    = 5'($urandom_range(0, 3));
         bus.id_raddr2    = 5'($urandom_range(0, 3));
         bus.ex_is_load   = 1'($urandom_range(0, 1));
         bus.ex_rf_we     = 1'($urandom_range(0, 1));
         bus.ex_rf_waddr  = 5'($urandom_range(0, 3));
         bus.ex_div_req   = ($urandom_range(0, 3) == 0);
         bus.div_ready    = ($urandom_range(0, 29) == 0);
         bus.div_cancel   = ($urandom_range(0, 29) == 0);
         bus.mem_stallreq = ($urandom_range(0, 5) == 0);
         settle();
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
